// File: rtl/vector_mem_sequencer_pkg.sv
// Shared definitions for the vector memory sequencer.
//   - default geometry constants (lanes, element width, address width, rd width)
//   - sequencer state encoding vmem_state_t
//   - vec_t: one full vector as a packed lane array
package vmem_pkg;

    localparam int unsigned VMEM_LANES  = 16;
    localparam int unsigned VMEM_ELEM_W = 16;
    localparam int unsigned VMEM_ADDR_W = 19;
    localparam int unsigned VMEM_RD_W   = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } vmem_state_t;

    typedef logic [VMEM_LANES-1:0][VMEM_ELEM_W-1:0] vec_t;

endpackage

// File: rtl/vector_mem_sequencer_if.sv
// Bus bundle between the MEM stage, the data RAM and the vector sequencer.
//   Pipeline side : start_read, start_write, base_addr, wdata_vec, rd_in (to sequencer)
//                   stall, done, rdata_vec, rd_out, err (from sequencer)
//   RAM side      : ram_q (to sequencer); ram_addr, ram_wdata, ram_wren (from sequencer)
// modport slave  : the sequencer
// modport master : the pipeline/RAM environment
interface vector_mem_sequencer_if #(
    parameter int unsigned LANES  = vmem_pkg::VMEM_LANES,
    parameter int unsigned ELEM_W = vmem_pkg::VMEM_ELEM_W,
    parameter int unsigned ADDR_W = vmem_pkg::VMEM_ADDR_W,
    parameter int unsigned RD_W   = vmem_pkg::VMEM_RD_W
);

    logic                               start_read;
    logic                               start_write;
    logic [ADDR_W-1:0]                  base_addr;
    logic [LANES-1:0][ELEM_W-1:0]       wdata_vec;
    logic [RD_W-1:0]                    rd_in;
    logic [ELEM_W-1:0]                  ram_q;

    logic [ADDR_W-1:0]                  ram_addr;
    logic [ELEM_W-1:0]                  ram_wdata;
    logic                               ram_wren;
    logic                               stall;
    logic                               done;
    logic [LANES-1:0][ELEM_W-1:0]       rdata_vec;
    logic [RD_W-1:0]                    rd_out;
    logic                               err;

    modport slave (
        input  start_read, start_write, base_addr, wdata_vec, rd_in, ram_q,
        output ram_addr, ram_wdata, ram_wren, stall, done, rdata_vec, rd_out, err
    );

    modport master (
        output start_read, start_write, base_addr, wdata_vec, rd_in, ram_q,
        input  ram_addr, ram_wdata, ram_wren, stall, done, rdata_vec, rd_out, err
    );

endinterface

// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer for the MEM stage.
// Serialises a LANES-wide vector store into consecutive RAM writes, or gathers
// LANES consecutive RAM words into a vector, holding the pipeline stalled for
// the whole transfer and pulsing done for one cycle at the end.
//   clk : core clock (RAM shares it)
//   rst : asynchronous active-low reset
//   bus : vector_mem_sequencer_if.slave (start/data in, RAM port, stall/done/err out)
module vector_mem_sequencer
    import vmem_pkg::*;
#(
    parameter int unsigned LANES  = VMEM_LANES,
    parameter int unsigned ELEM_W = VMEM_ELEM_W,
    parameter int unsigned ADDR_W = VMEM_ADDR_W,
    parameter int unsigned RD_W   = VMEM_RD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    vector_mem_sequencer_if.slave    bus
);

    localparam int unsigned        LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(LANES - 1);

    vmem_state_t                   r_state;
    logic [LANE_W-1:0]             r_lane;
    logic [LANE_W-1:0]             r_tag;
    logic                          r_cap;
    logic [ADDR_W-1:0]             r_base;
    logic [LANES-1:0][ELEM_W-1:0]  r_wvec;
    logic [RD_W-1:0]               r_rd;
    logic [ADDR_W-1:0]             r_addr;
    logic [ELEM_W-1:0]             r_wdata;
    logic                          r_wren;
    logic [LANES-1:0][ELEM_W-1:0]  r_rdata;
    logic [RD_W-1:0]               r_rd_out;

    logic                          w_any_start;
    logic                          w_accept;
    logic                          w_last;
    logic [LANE_W-1:0]             w_next_lane;
    logic [ADDR_W-1:0]             w_next_addr;

    always_comb begin
        w_any_start = bus.start_read | bus.start_write;
        // Gated by rst so stall/err stay low while reset is asserted.
        w_accept    = rst && (r_state == IDLE) && w_any_start;
        w_last      = (r_lane == LAST_LANE);
        w_next_lane = r_lane + LANE_W'(1);
        // Modulo 2^ADDR_W: the sum is truncated to the RAM address width.
        w_next_addr = r_base + ADDR_W'(w_next_lane);
    end

    assign bus.stall     = w_accept || (r_state == WRITE) || (r_state == READ) || (r_state == DRAIN);
    assign bus.done      = (r_state == DONE);
    assign bus.err       = w_accept && bus.start_read && bus.start_write;
    assign bus.ram_addr  = r_addr;
    assign bus.ram_wdata = r_wdata;
    assign bus.ram_wren  = r_wren;
    assign bus.rdata_vec = r_rdata;
    assign bus.rd_out    = r_rd_out;

    // RAM-facing outputs are registered one lane ahead: the accept cycle loads
    // lane 0, and each WRITE/READ cycle loads the next lane, so lane k is on
    // the RAM port in cycle k+1 and the port holds its value afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_lane   <= '0;
            r_tag    <= '0;
            r_cap    <= 1'b0;
            r_base   <= '0;
            r_wvec   <= '0;
            r_rd     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wren   <= 1'b0;
            r_rdata  <= '0;
            r_rd_out <= '0;
        end else begin
            r_cap <= 1'b0;
            // RAM read data arrives one cycle after its address; r_tag is the
            // lane that address belonged to.
            if (r_cap) begin
                r_rdata[r_tag] <= bus.ram_q;
            end

            case (r_state)
                IDLE: begin
                    if (w_any_start) begin
                        r_base <= bus.base_addr;
                        r_wvec <= bus.wdata_vec;
                        r_rd   <= bus.rd_in;
                        r_lane <= '0;
                        r_addr <= bus.base_addr;
                        r_wren <= bus.start_write;
                        if (bus.start_write) begin
                            r_wdata <= bus.wdata_vec[0];
                            r_state <= WRITE;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end

                WRITE, READ: begin
                    if (r_state == READ) begin
                        r_cap <= 1'b1;
                        r_tag <= r_lane;
                    end
                    if (w_last) begin
                        r_wren  <= 1'b0;
                        r_state <= (r_state == WRITE) ? DONE : DRAIN;
                    end else begin
                        r_lane <= w_next_lane;
                        r_addr <= w_next_addr;
                        if (r_state == WRITE) begin
                            r_wdata <= r_wvec[w_next_lane];
                        end
                    end
                end

                DRAIN: begin
                    r_rd_out <= r_rd;
                    r_state  <= DONE;
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: store, load, address wrap,
// read/write collision, busy start, and reset in the middle of a load.
// A small synchronous RAM model sits on the RAM side of the bus.
module tb_vector_mem_sequencer;
    import vmem_pkg::*;

    logic clk;
    logic rst;

    int unsigned errors;
    int unsigned checks;

    vector_mem_sequencer_if bus ();

    vector_mem_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 1024 words indexed by the low address bits, synchronous read.
    logic [15:0] mem [0:1023];
    logic        pre_en;
    logic [9:0]  pre_a;
    logic [15:0] pre_d;

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_a] <= pre_d;
        else if (bus.ram_wren)
            mem[bus.ram_addr[9:0]] <= bus.ram_wdata;
        bus.ram_q <= mem[bus.ram_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_starts();
        bus.start_read  = 1'b0;
        bus.start_write = 1'b0;
    endtask

    // Store of dbase+i to base+i; optional read/write collision in cycle 0 and
    // optional extra start in cycle 5 that must be ignored.
    task automatic do_store(input logic [18:0] base, input logic [15:0] dbase,
                            input bit collide, input bit busy_start, input string nm);
        next_cycle();
        bus.base_addr = base;
        for (int i = 0; i < 16; i++) bus.wdata_vec[i] = 16'(dbase + 16'(i));
        bus.rd_in       = 5'd3;
        bus.start_write = 1'b1;
        bus.start_read  = collide;
        @(negedge clk);
        chk($sformatf("%s c0 stall", nm), bus.stall, 1);
        chk($sformatf("%s c0 err", nm), bus.err, collide);
        chk($sformatf("%s c0 done", nm), bus.done, 0);
        for (int c = 1; c <= 18; c++) begin
            next_cycle();
            bus.start_write = busy_start && (c == 5);
            bus.start_read  = busy_start && (c == 5);
            @(negedge clk);
            if (c <= 16) begin
                chk($sformatf("%s c%0d wren", nm, c), bus.ram_wren, 1);
                chk($sformatf("%s c%0d addr", nm, c), bus.ram_addr, 19'(base + 19'(c - 1)));
                chk($sformatf("%s c%0d wdata", nm, c), bus.ram_wdata, 16'(dbase + 16'(c - 1)));
                chk($sformatf("%s c%0d stall", nm, c), bus.stall, 1);
                chk($sformatf("%s c%0d done", nm, c), bus.done, 0);
            end else if (c == 17) begin
                chk($sformatf("%s c17 done", nm), bus.done, 1);
                chk($sformatf("%s c17 stall", nm), bus.stall, 0);
                chk($sformatf("%s c17 wren", nm), bus.ram_wren, 0);
            end else begin
                chk($sformatf("%s c18 done", nm), bus.done, 0);
                chk($sformatf("%s c18 stall", nm), bus.stall, 0);
            end
            if (busy_start && c == 5)
                chk($sformatf("%s c5 err", nm), bus.err, 0);
        end
        clear_starts();
    endtask

    task automatic do_load(input logic [18:0] base, input logic [4:0] rd,
                           input vec_t expv, input string nm);
        next_cycle();
        bus.base_addr  = base;
        bus.rd_in      = rd;
        bus.start_read = 1'b1;
        @(negedge clk);
        chk($sformatf("%s c0 stall", nm), bus.stall, 1);
        chk($sformatf("%s c0 err", nm), bus.err, 0);
        for (int c = 1; c <= 18; c++) begin
            next_cycle();
            clear_starts();
            @(negedge clk);
            chk($sformatf("%s c%0d wren", nm, c), bus.ram_wren, 0);
            if (c <= 16) begin
                chk($sformatf("%s c%0d addr", nm, c), bus.ram_addr, 19'(base + 19'(c - 1)));
                chk($sformatf("%s c%0d stall", nm, c), bus.stall, 1);
                chk($sformatf("%s c%0d done", nm, c), bus.done, 0);
            end else if (c == 17) begin
                chk($sformatf("%s c17 stall", nm), bus.stall, 1);
                chk($sformatf("%s c17 done", nm), bus.done, 0);
            end else begin
                chk($sformatf("%s c18 done", nm), bus.done, 1);
                chk($sformatf("%s c18 stall", nm), bus.stall, 0);
                chk($sformatf("%s c18 rd_out", nm), bus.rd_out, rd);
                for (int i = 0; i < 16; i++)
                    chk($sformatf("%s lane%0d", nm, i), bus.rdata_vec[i], expv[i]);
            end
        end
    endtask

    initial begin
        vec_t exp_a;
        vec_t exp_b;
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        pre_en = 1'b0;
        pre_a  = '0;
        pre_d  = '0;
        bus.start_read  = 1'b0;
        bus.start_write = 1'b0;
        bus.base_addr   = '0;
        bus.wdata_vec   = '0;
        bus.rd_in       = '0;
        #1;
        chk("reset wren", bus.ram_wren, 0);
        chk("reset stall", bus.stall, 0);
        chk("reset done", bus.done, 0);
        chk("reset err", bus.err, 0);
        chk("reset addr", bus.ram_addr, 0);
        chk("reset rd_out", bus.rd_out, 0);

        // Preload mem[0x200+i] = 0x1111*i while reset is held.
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            pre_en = 1'b1;
            pre_a  = 10'(32'h200 + i);
            pre_d  = 16'(32'h1111 * i);
        end
        next_cycle();
        pre_en = 1'b0;
        rst    = 1'b1;

        for (int i = 0; i < 16; i++) begin
            exp_a[i] = 16'(32'h1111 * i);
            exp_b[i] = 16'(32'hA000 + i);
        end

        do_store(19'h00100, 16'hA000, 1'b0, 1'b0, "store");
        do_load(19'h00200, 5'd7, exp_a, "load");
        do_load(19'h00100, 5'd12, exp_b, "readback");
        do_store(19'h7FFF8, 16'hB000, 1'b0, 1'b0, "wrap");
        do_store(19'h00300, 16'hD000, 1'b1, 1'b1, "collide");
        chk("collide rd_out kept", bus.rd_out, 12);

        // Reset asserted in cycle 9 of a load.
        next_cycle();
        bus.base_addr  = 19'h00200;
        bus.rd_in      = 5'd9;
        bus.start_read = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            clear_starts();
        end
        rst = 1'b0;
        #1;
        chk("rst wren", bus.ram_wren, 0);
        chk("rst stall", bus.stall, 0);
        chk("rst done", bus.done, 0);
        chk("rst err", bus.err, 0);
        chk("rst addr", bus.ram_addr, 0);
        chk("rst wdata", bus.ram_wdata, 0);
        chk("rst rd_out", bus.rd_out, 0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("rst lane%0d", i), bus.rdata_vec[i], 0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("post-rst stall", bus.stall, 0);
        chk("post-rst done", bus.done, 0);
        do_store(19'h00100, 16'hC000, 1'b0, 1'b0, "after-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Sequences vector loads and stores in the MEM stage over the single 16-bit-wide data RAM. On a start pulse it serialises one 16-lane vector into 16 consecutive RAM element accesses, or gathers 16 consecutive RAM elements into a vector. It holds the pipeline stall high for the whole transfer, then reports a one-cycle done pulse. It replaces the free-running mem_addr/input/output managers and their separate slow memory clock; the RAM runs on the core clock.

## Interface
- LANES, 16, vector lanes transferred per operation (power of two)
- ELEM_W, 16, bits per element and per RAM word
- ADDR_W, 19, RAM address width
- RD_W, 5, destination register index width
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start_read  in  1  pulse: begin vector load (EnableRead from EX/MEM)
- start_write  in  1  pulse: begin vector store (EnableWrite from EX/MEM)
- base_addr  in  ADDR_W  element address of lane 0, sampled on accepted start
- wdata_vec  in  LANES×ELEM_W  store data, sampled on accepted start
- rd_in  in  RD_W  load destination register, sampled on accepted start
- ram_q  in  ELEM_W  RAM read data, valid one cycle after address
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  ELEM_W  RAM write data
- ram_wren  out  1  RAM write enable
- stall  out  1  freeze IF..EX/MEM registers
- done  out  1  one-cycle completion pulse
- rdata_vec  out  LANES×ELEM_W  gathered load vector, held until next load is accepted
- rd_out  out  RD_W  destination register of the last completed load
- err  out  1  one-cycle pulse: start_read and start_write both high in the same cycle

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: a start is accepted when it is seen in IDLE. Accepting latches base_addr, wdata_vec and rd_in, and clears lane = 0.
  - start_write goes to WRITE.
  - start_read goes to READ.
  - If both are high: write wins, the read is dropped, and err pulses.
- Starts seen in any other state are ignored, with no error.
- WRITE:
  - ram_addr = base + lane; ram_wdata = wdata_vec[lane]; ram_wren = 1; lane increments.
  - After lane LANES-1, go to DONE.
- READ:
  - ram_addr = base + lane, with ram_wren = 0.
  - A delayed lane tag captures ram_q into rdata_vec[tag] on the following cycle.
  - After lane LANES-1, go to DRAIN.
- DRAIN: captures the final lane, then goes to DONE.
- DONE: done = 1, then go to IDLE. On a load, rd_out updates on entry to DONE.
- Address arithmetic: ADDR_W-bit modulo, so base 0x7FFFF with lane 1 gives 0x00000.
- stall:
  - Combinationally high in IDLE when any start is high.
  - High in WRITE, READ and DRAIN.
  - Low in DONE.
- Reset, including mid-transfer:
  - State goes to IDLE and lane to 0.
  - ram_wren = 0 immediately; stall = 0, done = 0, err = 0.
  - rdata_vec = 0, rd_out = 0, ram_addr = 0, ram_wdata = 0.
  - A partial store is not completed and a partial load is discarded.

## Timing
- Cycle 0 is the start cycle; stall is already high in cycle 0.
- Store:
  - Cycles 1..LANES: writes, with lane k written in cycle k+1.
  - Cycle LANES+1 (17): done.
- Load:
  - Cycles 1..LANES: issue.
  - Cycles 2..LANES+1: capture.
  - Cycle LANES+2 (18): done, with rdata_vec and rd_out valid.
- The earliest next accepted start is the cycle after done, so there is no back-to-back overlap.
- Outside WRITE, ram_wren is low; ram_addr and ram_wdata hold their last values.

## Structure
- Package vmem_pkg:
  - state enum vmem_state_t (IDLE, WRITE, READ, DRAIN, DONE);
  - default constants VMEM_LANES, VMEM_ELEM_W, VMEM_ADDR_W;
  - a vector typedef vec_t = logic [LANES-1:0][ELEM_W-1:0].
- Single module; no sub-module is needed. The lane counter and the capture tag register are internal.

## Test plan
- Store:
  - Stimulus: base 0x00100, wdata_vec[i] = 0xA000+i, start_write in cycle 0.
  - Required: ram_wren high in cycles 1..16 with addr 0x00100+i and data 0xA000+i; stall high in cycles 0..16; done in cycle 17.
- Load:
  - Stimulus: RAM model preloaded mem[0x200+i] = 0x1111*i (mod 2^16); start_read with rd_in = 7.
  - Required: done in cycle 18; rdata_vec[i] matches; rd_out = 7; ram_wren never high.
- Wrap:
  - Stimulus: base 0x7FFF8, store.
  - Required: addresses 0x7FFF8..0x7FFFF, then 0x00000..0x00007.
- Collision and busy:
  - Stimulus: start_read and start_write high together.
  - Required: err pulse and a store only.
  - Stimulus: a second start in cycle 5.
  - Required: it is ignored; done occurs once, in cycle 17.
- Reset mid-load:
  - Stimulus: rst low in cycle 9.
  - Required: ram_wren, stall, done and rdata_vec all 0 at once; IDLE after release.
  - Stimulus: a new store after release.
  - Required: completes normally in 17 cycles.
